// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative 32-bit multiply / divide unit with HI/LO result registers.
//   It retires one bit per clock: 32 iterations plus a final cycle that applies
//   the sign fix-up and loads HI/LO. Total latency is 33 cycles after start.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin a new operation (only honoured while idle)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   : operands (multiplicand/dividend, multiplier/divisor)
//   hi_we  : MTHI write enable (idle only, start has priority)
//   lo_we  : MTLO write enable (idle only, start has priority)
//   wd     : MTHI/MTLO write data
//   busy   : operation in flight
//   done   : one-cycle pulse after HI/LO were loaded with a result
//   hi, lo : HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  count_reg;

    // work_hi/work_lo: partial product (mul) or remainder/quotient (div).
    // operand_reg: |multiplicand| for mul, |divisor| for div.
    logic [31:0] work_hi_reg;
    logic [31:0] work_lo_reg;
    logic [31:0] operand_reg;
    logic        is_div_reg;
    logic        neg_res_reg;
    logic        neg_rem_reg;

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // ---------------- operand preparation (used at the start edge) ----------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        b_zero;

    always_comb begin
        // op[0]=1 selects the unsigned variants
        a_neg  = ~op[0] & a[31];
        b_neg  = ~op[0] & b[31];
        a_abs  = a_neg ? (32'd0 - a) : a;
        b_abs  = b_neg ? (32'd0 - b) : b;
        b_zero = (b == 32'd0);
    end

    // ---------------- one iteration step ------------------------------------
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [31:0] step_hi;
    logic [31:0] step_lo;

    always_comb begin
        // Radix-2 shift-add: add multiplicand when multiplier LSB is set,
        // then shift the 65-bit {carry, hi, lo} right by one.
        mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : 33'd0);
        // Restoring division: shift next dividend bit into the remainder.
        div_shift = {work_hi_reg, work_lo_reg[31]};
        div_ge    = (div_shift >= {1'b0, operand_reg});
        // The remainder is always below the divisor, so a successful
        // subtraction always fits back into 32 bits.
        div_sub   = div_shift[31:0] - operand_reg;
        if (is_div_reg) begin
            step_hi = div_ge ? div_sub : div_shift[31:0];
            step_lo = {work_lo_reg[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], work_lo_reg[31:1]};
        end
    end

    // ---------------- sign correction ---------------------------------------
    logic [63:0] prod_neg;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        prod_neg = 64'd0 - {work_hi_reg, work_lo_reg};
        if (is_div_reg) begin
            fix_lo = neg_res_reg ? (32'd0 - work_lo_reg) : work_lo_reg;
            fix_hi = neg_rem_reg ? (32'd0 - work_hi_reg) : work_hi_reg;
        end else begin
            fix_hi = neg_res_reg ? prod_neg[63:32] : work_hi_reg;
            fix_lo = neg_res_reg ? prod_neg[31:0]  : work_lo_reg;
        end
    end

    // ---------------- FSM: state register -----------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ---------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count_reg == 6'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ------------------------------------------
    always_comb begin
        busy = (state_reg != IDLE);
        done = done_reg;
        hi   = hi_reg;
        lo   = lo_reg;
    end

    // ---------------- datapath ----------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg   <= 6'd0;
            work_hi_reg <= 32'd0;
            work_lo_reg <= 32'd0;
            operand_reg <= 32'd0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg   <= 6'd0;
                        work_hi_reg <= 32'd0;
                        work_lo_reg <= op[1] ? a_abs : b_abs;
                        operand_reg <= op[1] ? b_abs : a_abs;
                        is_div_reg  <= op[1];
                        // A zero divisor yields an all-ones quotient and the
                        // dividend as remainder; suppressing the quotient
                        // negation keeps that true for signed DIV as well.
                        neg_res_reg <= op[1] ? ((a_neg ^ b_neg) & ~b_zero) : (a_neg ^ b_neg);
                        neg_rem_reg <= a_neg;
                    end else begin
                        if (hi_we) hi_reg <= wd;
                        if (lo_we) lo_reg <= wd;
                    end
                end
                RUN: begin
                    work_hi_reg <= step_hi;
                    work_lo_reg <= step_lo;
                    count_reg   <= count_reg + 6'd1;
                end
                FIX: begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed testbench for muldiv_unit. Stimulus pushes expected HI/LO results
//   into a scoreboard queue; a monitor on the falling edge pops and checks on
//   every done pulse, including the busy length of the operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   busy_cnt  = 0;
    int   done_seen = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, req);
        end else begin
            $display("[TB] ok   %s: %08h", name, act);
        end
    endfunction

    // ---------------- monitor -----------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                done_seen++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: hi=%08h lo=%08h, no result expected", hi, lo);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".hi"}, hi, e.hi);
                    chk({e.name, ".lo"}, lo, e.lo);
                    chk({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
                    chk({e.name, ".busy_with_done"}, {31'd0, busy}, 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic hwe, input logic lwe, input logic [31:0] w);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = av; b = bv; hi_we = hwe; lo_we = lwe; wd = w;
        @(posedge clk); #1;
        // operands must have been latched; scramble them
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom; wd = $urandom;
    endtask

    task automatic wait_done(input string name);
        int base = done_seen;
        int k = 0;
        while (done_seen == base && k < 60) begin
            @(posedge clk);
            k++;
        end
        if (done_seen == base) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s.timeout: no done within %0d cycles, expected done", name, k);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.name = name; e.hi = eh; e.lo = el;
        sb.push_back(e);
        issue(o, av, bv, 1'b0, 1'b0, 32'd0);
        wait_done(name);
    endtask

    task automatic idle_write(input logic hwe, input logic lwe, input logic [31:0] w);
        @(posedge clk); #1;
        hi_we = hwe; lo_we = lwe; wd = w;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        int done_before;
        exp_t e;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        rst_n = 1'b1;

        // idle MTHI / MTLO
        idle_write(1'b1, 1'b0, 32'h1111_1111);
        chk("mthi.hi", hi, 32'h1111_1111);
        chk("mthi.lo", lo, 32'h0000_0000);
        idle_write(1'b0, 1'b1, 32'h2222_2222);
        chk("mtlo.hi", hi, 32'h1111_1111);
        chk("mtlo.lo", lo, 32'h2222_2222);
        idle_write(1'b1, 1'b1, 32'h3333_3333);
        chk("mtboth.hi", hi, 32'h3333_3333);
        chk("mtboth.lo", lo, 32'h3333_3333);

        // arithmetic vectors
        run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_neg2xneg3", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);
        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("multu_shift", 2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
        run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7byneg2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100by7", 2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
        run_op("divu_by0",    2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // start together with MTHI in an idle cycle: start wins
        e.name = "start_beats_mthi"; e.hi = 32'h0000_0000; e.lo = 32'h0000_0006;
        sb.push_back(e);
        issue(2'b01, 32'd2, 32'd3, 1'b1, 1'b1, 32'hAAAA_AAAA);
        wait_done("start_beats_mthi");

        // start and MTHI while busy are ignored
        e.name = "busy_ignores"; e.hi = 32'h0000_0000; e.lo = 32'h0000_000C;
        sb.push_back(e);
        issue(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);   // returns just after edge T+1
        repeat (3) @(posedge clk);                        // after edge T+4
        #1;
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;                               // edge T+5
        start = 1'b0; hi_we = 1'b0;
        wait_done("busy_ignores");
        idle_write(1'b0, 1'b1, 32'h1234_5678);
        chk("mtlo_after.lo", lo, 32'h1234_5678);
        chk("mtlo_after.hi", hi, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        chk("no_extra_done.queue", 32'(sb.size()), 32'd0);

        // reset mid-operation aborts
        idle_write(1'b1, 1'b0, 32'h5555_5555);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, 32'd0);
        repeat (8) @(posedge clk);                        // after edge T+9
        #1;
        rst_n = 1'b0;
        done_before = done_seen;
        @(posedge clk); #1;                               // edge T+10
        rst_n = 1'b1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort.no_done", 32'(done_seen - done_before), 32'd0);
        chk("abort.hi_hold", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: none; operand width fixed at 32 bits, iteration count fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request new operation; sampled only while busy=0.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  operand A (multiplicand / dividend), driven from register-file rd1.
REQ-007 b  input  32  operand B (multiplier / divisor), driven from register-file rd2.
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wd  input  32  MTHI/MTLO write data.
REQ-011 busy  output  1  operation in progress; pipeline stalls on MFHI/MFLO/new mul-div while high.
REQ-012 done  output  1  one-cycle pulse: HI/LO just updated by a completed operation.
REQ-013 hi  output  32  HI register (product upper word / remainder), registered.
REQ-014 lo  output  32  LO register (product lower word / quotient), registered.

Function
REQ-015 FSM states IDLE, RUN, FIX; IDLE->RUN on start at edge T; RUN->FIX after 32nd iteration; FIX->IDLE after one cycle.
REQ-016 Edge T: a, b, op latched; signed ops store absolute values plus result-sign and remainder-sign flags; later changes of a/b/op have no effect.
REQ-017 Iterations on edges T+1..T+32, one bit per edge, 6-bit counter; MULT/MULTU radix-2 shift-add, DIV/DIVU restoring shift-subtract.
REQ-018 Edge T+33 (FIX): sign correction applied, HI/LO loaded, busy cleared, done=1 for the following cycle only.
REQ-019 busy=1 for exactly 33 cycles (after edge T through edge T+33); done and busy never high together.
REQ-020 MULT/MULTU: {hi,lo} = full 64-bit signed/unsigned product, exact.
REQ-021 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend (signed) or unsigned.
REQ-022 Divide by zero (DIV or DIVU): lo = 0xFFFFFFFF, hi = a; no trap; latency unchanged.
REQ-023 Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-024 start while busy=1: ignored; in-flight operation unaffected.
REQ-025 hi_we/lo_we while busy=1 (including FIX cycle): ignored.
REQ-026 hi_we/lo_we while busy=0 and start=0: hi/lo <= wd at that edge; both asserted loads both.
REQ-027 start and hi_we/lo_we in same idle cycle: start wins, write discarded.
REQ-028 hi/lo hold value at all other times; outputs change only at edges named above.

Reset
REQ-029 rst_n=0 at an edge: state IDLE, counter 0, busy=0, done=0, hi=0x00000000, lo=0x00000000.
REQ-030 Reset mid-operation (RUN or FIX) aborts: no done pulse, no HI/LO update from aborted operation.
REQ-031 rst_n has priority over start, hi_we, lo_we.

Verification
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles, done pulse, hi=0xFFFFFFFE lo=0x00000001.
REQ-033 MULT a=0xFFFFFFFD(-3) b=0x00000005 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
REQ-034 DIV a=0xFFFFFFF9(-7) b=0x00000002 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF hi=0x00000007.
REQ-035 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0x00000000.
REQ-036 MULTU 3*4 started, then start (DIVU 9/2) and hi_we wd=0xDEADBEEF at cycle T+5 -> both ignored, hi=0 lo=0x0000000C; then idle lo_we wd=0x12345678 -> lo=0x12345678.
REQ-037 MULT in flight, rst_n=0 at T+10 for one edge -> busy=0, hi=lo=0 next cycle, no done pulse within following 40 cycles.
